// File: rtl/mont_expo_param.sv
// Purpose: z = x^e mod n by left-to-right square-and-multiply over a bit-serial radix-2 Montgomery multiplier.
// Latency: 1 + (WIDTH+3+popcount(e))*(WIDTH+1) cycles from start accept to done; 1 cycle for an illegal modulus.
// Backpressure: none; start is a level request sampled only in IDLE, and is ignored while busy.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           level request, sampled in IDLE; x/e/n/r2 are captured on that edge
//   x, e, n, r2     base, exponent, odd modulus (>= 3), R^2 mod n with R = 2^WIDTH
//   z               result register, updated only on completion
//   done            one-cycle completion pulse
//   busy            high from the accepted start until done
//   err             status of last completed operation (1 = illegal modulus)
module mont_expo_param #(
    parameter int WIDTH = 192,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] z,
    output logic             done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, CHECK, PRE_X, PRE_ACC, SQR, MUL, POST, DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state, state_nxt;

    // Captured operands. e_sh is shifted left as k counts down, so its MSB is always e[k].
    logic [WIDTH-1:0] x_r, e_sh, n_r, r2_r;
    logic [WIDTH-1:0] xm;               // x in Montgomery form
    logic [WIDTH-1:0] mm_a, mm_b;       // multiplier operands; mm_a shifts right one bit per cycle
    logic [WIDTH+1:0] t;                // Montgomery accumulator
    logic [CNT_W-1:0] cyc;              // cycle within the current multiply, 0..WIDTH
    logic [CNT_W-1:0] k;                // exponent bit index

    logic             mm_last;
    logic             k_zero;
    logic             e_bit;
    logic             illegal;
    logic [WIDTH+1:0] ab;
    logic [WIDTH+1:0] s;
    logic [WIDTH+1:0] addn;
    logic [WIDTH+1:0] t_step;
    logic [WIDTH-1:0] res;

    assign mm_last = (cyc == CNT_W'(WIDTH));
    assign k_zero  = (k == '0);
    assign e_bit   = e_sh[WIDTH-1];
    assign illegal = !n_r[0] || (n_r < WIDTH'(3));

    // One radix-2 step: s = T + a[i]*b, add n when s is odd so the halving is exact.
    // With b < n the accumulator stays below 2n, so s + n < 4n fits in WIDTH+2 bits.
    always_comb begin
        ab     = mm_a[0] ? {2'b00, mm_b} : '0;
        s      = t + ab;
        addn   = s[0] ? {2'b00, n_r} : '0;
        t_step = (s + addn) >> 1;
    end

    // Final conditional subtraction, evaluated during the last cycle of each multiply.
    always_comb begin
        if (t >= {2'b00, n_r}) begin
            res = WIDTH'(t - {2'b00, n_r});
        end else begin
            res = t[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = illegal ? DONE : PRE_X;
            end
            PRE_X: begin
                busy = 1'b1;
                if (mm_last) state_nxt = PRE_ACC;
            end
            PRE_ACC: begin
                busy = 1'b1;
                if (mm_last) state_nxt = SQR;
            end
            SQR: begin
                busy = 1'b1;
                if (mm_last) begin
                    if (e_bit) begin
                        state_nxt = MUL;
                    end else if (k_zero) begin
                        state_nxt = POST;
                    end
                end
            end
            MUL: begin
                busy = 1'b1;
                if (mm_last) state_nxt = k_zero ? POST : SQR;
            end
            POST: begin
                busy = 1'b1;
                if (mm_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z    <= '0;
            err  <= 1'b0;
            x_r  <= '0;
            e_sh <= '0;
            n_r  <= '0;
            r2_r <= '0;
            xm   <= '0;
            mm_a <= '0;
            mm_b <= '0;
            t    <= '0;
            cyc  <= '0;
            k    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r  <= x;
                        e_sh <= e;
                        n_r  <= n;
                        r2_r <= r2;
                    end
                end
                CHECK: begin
                    if (illegal) begin
                        z   <= '0;
                        err <= 1'b1;
                    end else begin
                        mm_a <= x_r;
                        mm_b <= r2_r;
                        t    <= '0;
                        cyc  <= '0;
                    end
                end
                PRE_X, PRE_ACC, SQR, MUL, POST: begin
                    if (!mm_last) begin
                        t    <= t_step;
                        mm_a <= mm_a >> 1;
                        cyc  <= cyc + 1'b1;
                    end else begin
                        // Multiply finished: store the result and load the next multiply's operands.
                        t   <= '0;
                        cyc <= '0;
                        if (state == PRE_X) begin
                            xm   <= res;
                            mm_a <= ONE;
                            mm_b <= r2_r;
                        end else if (state == PRE_ACC) begin
                            mm_a <= res;
                            mm_b <= res;
                            k    <= CNT_W'(WIDTH - 1);
                        end else if (state == SQR && e_bit) begin
                            mm_a <= res;
                            mm_b <= xm;
                        end else if (state == SQR || state == MUL) begin
                            mm_a <= res;
                            if (k_zero) begin
                                mm_b <= ONE;
                            end else begin
                                mm_b <= res;
                                k    <= k - 1'b1;
                                e_sh <= e_sh << 1;
                            end
                        end else begin
                            z   <= res;
                            err <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
